// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and constants for the scoreboard timer digit chains
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam logic [3:0]  BCD_MAX          = 4'd9;
    localparam logic [19:0] DEFAULT_TICK_DIV = 20'd1000000;

    // Out-of-range nibbles clamp to 9 rather than being rejected.
    function automatic logic [3:0] bcd_sat(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control strobes and BCD display outputs of the countdown timer
interface countdown_timer_if;

    logic        load;
    logic [15:0] load_value;
    logic        start;
    logic        pause;
    logic [15:0] digits;
    logic        running;
    logic        expired;
    logic        done_pulse;

    modport master (
        output load, load_value, start, pause,
        input  digits, running, expired, done_pulse
    );

    modport slave (
        input  load, load_value, start, pause,
        output digits, running, expired, done_pulse
    );

endinterface

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD digit with saturating load and decrement/borrow chaining
module bcd_down_digit
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic [3:0] value_o,
    output logic       borrow_o
);

    logic [3:0] value_q;
    logic [3:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = bcd_sat(load_val_i);
        end else if (dec_i) begin
            value_d = (value_q == 4'd0) ? BCD_MAX : value_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o  = value_q;
    assign borrow_o = dec_i && (value_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - four-digit BCD shot/game clock: FSM, hundredth prescaler and zero detect
module countdown_timer
    import timer_pkg::*;
#(
    parameter logic [19:0] TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    countdown_timer_if.slave  tif
);

    state_e      state_q;
    state_e      state_d;
    logic [19:0] prescaler_q;
    logic [19:0] prescaler_d;
    logic        done_pulse_q;
    logic        done_pulse_d;

    logic [15:0] digits_q;
    logic [4:0]  borrow;
    logic        load_accept;
    logic        tick;
    logic        digits_zero;
    logic        dec_en;
    logic        expire_next;

    assign load_accept = tif.load && (state_q != RUN);
    assign tick        = (state_q == RUN) && (prescaler_q == TICK_DIV - 20'd1);
    assign digits_zero = (digits_q == 16'h0000);
    // A pause on the tick cycle wins, so the decrement is dropped entirely.
    assign dec_en      = tick && !tif.pause && !digits_zero;
    assign expire_next = dec_en && (digits_q == 16'h0001);

    assign borrow[0] = dec_en;

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .load_i     (load_accept),
            .load_val_i (tif.load_value[i*4 +: 4]),
            .dec_i      (borrow[i]),
            .value_o    (digits_q[i*4 +: 4]),
            .borrow_o   (borrow[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            prescaler_q  <= 20'd0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prescaler_q  <= prescaler_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (tif.load) begin
                    state_d = IDLE;
                end else if (tif.start && !digits_zero) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A borrow out of the top digit means the chain underflowed; stop there.
                if (tif.pause) begin
                    state_d = PAUSED;
                end else if (expire_next || borrow[4]) begin
                    state_d = EXPIRED;
                end
            end
            PAUSED: begin
                if (tif.load) begin
                    state_d = IDLE;
                end else if (tif.start) begin
                    state_d = RUN;
                end
            end
            EXPIRED: begin
                if (tif.load) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prescaler_d  = prescaler_q;
        done_pulse_d = (state_q == RUN) && (state_d == EXPIRED);
        if (load_accept) begin
            prescaler_d = 20'd0;
        end else if ((state_q == RUN) && !tif.pause) begin
            prescaler_d = tick ? 20'd0 : prescaler_q + 20'd1;
        end
    end

    assign tif.digits     = digits_q;
    assign tif.running    = (state_q == RUN);
    assign tif.expired    = (state_q == EXPIRED);
    assign tif.done_pulse = done_pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer with TICK_DIV=4
module tb_countdown_timer;

    typedef struct {
        logic [15:0] digits;
        logic        running;
        logic        expired;
        logic        done_pulse;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    bit   mon_en = 1'b0;
    logic [18:0] prev_snap;
    exp_t expq[$];

    countdown_timer_if tif();

    countdown_timer #(.TICK_DIV(20'd4)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [18:0] snap();
        return {tif.digits, tif.running, tif.expired, tif.done_pulse};
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] != 4'd0) begin
                r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                return r;
            end
            r[i*4 +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Monitor: every change of the output bundle must match the next queued expectation.
    always @(negedge clk) begin
        logic [18:0] s;
        exp_t        e;
        int          gap;
        if (mon_en) begin
            s = snap();
            if (s !== prev_snap) begin
                gap      = cyc - last_cyc;
                last_cyc = cyc;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: got %h want no change", s);
                end else begin
                    e = expq.pop_front();
                    if (s !== {e.digits, e.running, e.expired, e.done_pulse}) begin
                        bad++;
                        $display("FAIL outputs: got digits=%h run=%b exp=%b done=%b want digits=%h run=%b exp=%b done=%b",
                                 s[18:3], s[2], s[1], s[0], e.digits, e.running, e.expired, e.done_pulse);
                    end
                    if (e.gap >= 0) begin
                        total++;
                        if (gap != e.gap) begin
                            bad++;
                            $display("FAIL gap digits=%h: got %0d cycles want %0d", e.digits, gap, e.gap);
                        end
                    end
                end
            end
            prev_snap = s;
        end
    end

    task automatic expect_ev(input logic [15:0] d, input logic r, input logic x, input logic dp, input int gap);
        exp_t e;
        e.digits     = d;
        e.running    = r;
        e.expired    = x;
        e.done_pulse = dp;
        e.gap        = gap;
        expq.push_back(e);
    endtask

    task automatic strobe(input logic l, input logic [15:0] v, input logic s, input logic p);
        tif.load       = l;
        tif.load_value = v;
        tif.start      = s;
        tif.pause      = p;
        @(posedge clk);
        #1;
        tif.load  = 1'b0;
        tif.start = 1'b0;
        tif.pause = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        logic [15:0] v;
        tif.load       = 1'b0;
        tif.load_value = 16'h0000;
        tif.start      = 1'b0;
        tif.pause      = 1'b0;

        // Reset and idle start with a zero preset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("reset_digits", {16'h0, tif.digits}, 32'h0);
        check("reset_running", {31'h0, tif.running}, 32'h0);
        check("reset_expired", {31'h0, tif.expired}, 32'h0);
        check("reset_done", {31'h0, tif.done_pulse}, 32'h0);
        prev_snap = snap();
        last_cyc  = cyc;
        mon_en    = 1'b1;
        strobe(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(3);
        check("t1_drained", expq.size(), 0);

        // Full countdown from 00.12
        expect_ev(16'h0012, 1'b0, 1'b0, 1'b0, -1);
        strobe(1'b1, 16'h0012, 1'b0, 1'b0);
        expect_ev(16'h0012, 1'b1, 1'b0, 1'b0, 1);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0);
        v = 16'h0012;
        repeat (11) begin
            v = bcd_dec(v);
            expect_ev(v, 1'b1, 1'b0, 1'b0, 4);
        end
        expect_ev(16'h0000, 1'b0, 1'b1, 1'b1, 4);
        expect_ev(16'h0000, 1'b0, 1'b1, 1'b0, 1);
        idle(60);
        check("t2_drained", expq.size(), 0);
        check("t2_expired_held", {31'h0, tif.expired}, 32'h1);

        // Load zero from EXPIRED, then start is ignored
        expect_ev(16'h0000, 1'b0, 1'b0, 1'b0, -1);
        strobe(1'b1, 16'h0000, 1'b0, 1'b0);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(5);
        check("zero_start_drained", expq.size(), 0);

        // Borrow ripple 10.00 -> 09.99 -> 09.98
        expect_ev(16'h1000, 1'b0, 1'b0, 1'b0, -1);
        strobe(1'b1, 16'h1000, 1'b0, 1'b0);
        expect_ev(16'h1000, 1'b1, 1'b0, 1'b0, 1);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0);
        expect_ev(16'h0999, 1'b1, 1'b0, 1'b0, 4);
        expect_ev(16'h0998, 1'b1, 1'b0, 1'b0, 4);
        idle(8);
        expect_ev(16'h0998, 1'b0, 1'b0, 1'b0, 1);
        strobe(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(3);
        check("t3_drained", expq.size(), 0);

        // Pause at prescaler=2, hold 20 cycles, resume keeps the fraction
        expect_ev(16'h0005, 1'b0, 1'b0, 1'b0, -1);
        strobe(1'b1, 16'h0005, 1'b0, 1'b0);
        expect_ev(16'h0005, 1'b1, 1'b0, 1'b0, 1);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(2);
        expect_ev(16'h0005, 1'b0, 1'b0, 1'b0, 3);
        strobe(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(20);
        expect_ev(16'h0005, 1'b1, 1'b0, 1'b0, 21);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0);
        expect_ev(16'h0004, 1'b1, 1'b0, 1'b0, 2);
        idle(2);
        expect_ev(16'h0004, 1'b0, 1'b0, 1'b0, 1);
        strobe(1'b0, 16'h0000, 1'b1, 1'b1);

        // Load rules: ignored in RUN, saturating in PAUSED, load beats start in IDLE
        expect_ev(16'h0004, 1'b1, 1'b0, 1'b0, 1);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0);
        strobe(1'b1, 16'h0300, 1'b0, 1'b0);
        expect_ev(16'h0003, 1'b1, 1'b0, 1'b0, 4);
        idle(3);
        expect_ev(16'h0003, 1'b0, 1'b0, 1'b0, 1);
        strobe(1'b0, 16'h0000, 1'b0, 1'b1);
        expect_ev(16'h9999, 1'b0, 1'b0, 1'b0, 1);
        strobe(1'b1, 16'hABCD, 1'b0, 1'b0);
        expect_ev(16'h0042, 1'b0, 1'b0, 1'b0, 1);
        strobe(1'b1, 16'h0042, 1'b1, 1'b0);
        idle(10);
        check("t45_drained", expq.size(), 0);

        // Pause on the final tick: stays at 00.01, then resume expires at once
        expect_ev(16'h0001, 1'b0, 1'b0, 1'b0, -1);
        strobe(1'b1, 16'h0001, 1'b0, 1'b0);
        expect_ev(16'h0001, 1'b1, 1'b0, 1'b0, 1);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(3);
        expect_ev(16'h0001, 1'b0, 1'b0, 1'b0, 4);
        strobe(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(5);
        expect_ev(16'h0001, 1'b1, 1'b0, 1'b0, -1);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0);
        expect_ev(16'h0000, 1'b0, 1'b1, 1'b1, 1);
        expect_ev(16'h0000, 1'b0, 1'b1, 1'b0, 1);
        idle(4);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0);
        strobe(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(3);
        check("final_tick_drained", expq.size(), 0);

        // Reset mid-run aborts without done_pulse
        expect_ev(16'h0050, 1'b0, 1'b0, 1'b0, -1);
        strobe(1'b1, 16'h0050, 1'b0, 1'b0);
        expect_ev(16'h0050, 1'b1, 1'b0, 1'b0, 1);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0);
        expect_ev(16'h0049, 1'b1, 1'b0, 1'b0, 4);
        expect_ev(16'h0048, 1'b1, 1'b0, 1'b0, 4);
        expect_ev(16'h0000, 1'b0, 1'b0, 1'b0, 2);
        idle(9);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("t6_running", {31'h0, tif.running}, 32'h0);
        check("t6_digits", {16'h0, tif.digits}, 32'h0);
        idle(20);
        check("t6_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Four-digit BCD countdown timer (tens of seconds, seconds, tenths, hundredths) for the scoreboard's shot/game clock.
- It is the down-counting counterpart of the stopwatch digit chain: it is loaded with a preset, decrements one hundredth per tick, and flags expiry at 00.00.
- Its digit outputs feed the existing char_display instances unchanged.

Parameters:
- TICK_DIV, 20'd1000000: clock cycles per hundredth-second tick (100 MHz clock gives 10 ms). Legal range is 2 or more.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- load  input  1  load preset, single-cycle strobe
- load_value  input  16  preset in BCD: [15:12] tens, [11:8] seconds, [7:4] tenths, [3:0] hundredths
- start  input  1  start/resume strobe
- pause  input  1  pause strobe
- digits  output  16  current BCD value, same packing as load_value
- running  output  1  high while in RUN
- expired  output  1  level, high while in EXPIRED
- done_pulse  output  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst: when rst=0 at a rising edge, the block resets.
- Reset values: state=IDLE, digits=16'h0000, prescaler=0, running=0, expired=0, done_pulse=0. Reset mid-run aborts immediately with no done_pulse.
- States: IDLE, RUN, PAUSED, EXPIRED. All outputs are registered; running and expired decode the state register.
- Prescaler, 20 bits:
  - Increments only in RUN; holds in PAUSED, so a resume keeps the fractional period.
  - At TICK_DIV-1 it wraps to 0 and asserts an internal tick for that cycle.
  - It is cleared on reset and on an accepted load.
- Decrement on tick, in RUN only:
  - Hundredths digit decrements.
  - A digit at 0 borrows: it becomes 9 and the next digit up decrements. The borrow ripples combinationally within one cycle.
  - The value never wraps below 0000.
  - If the post-decrement value is 0000, the next state is EXPIRED and done_pulse is high for exactly that one cycle (the first cycle expired=1).
- Transitions, by priority within each state:
  - IDLE: load → IDLE with new value. Otherwise start with digits≠0 → RUN. Start with digits=0 is ignored and produces no pulse.
  - RUN: pause → PAUSED. Otherwise a tick reaching zero → EXPIRED. load and start are ignored.
  - PAUSED: load → IDLE with new value. Otherwise start → RUN. pause is ignored.
  - EXPIRED: load → IDLE with new value. start and pause are ignored. The digits hold at 0000.
  - Simultaneous start and pause in RUN: pause wins. Pause on the same cycle as the final tick: pause wins, the decrement is suppressed, and the state becomes PAUSED at 00.01.
- Load:
  - Each BCD nibble greater than 9 saturates to 9, so 16'hABCD becomes 16'h9999.
  - digits update on the cycle after the strobe.
  - Loading 0000 is legal; the block then stays in IDLE.
- Latency:
  - start → running=1 after one cycle.
  - First decrement occurs TICK_DIV cycles after RUN entry from a cleared prescaler.

Decomposition:
- Shared package (timer_pkg) holds:
  - the state enum encoding (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, EXPIRED=2'd3);
  - the BCD_MAX=4'd9 constant;
  - the default TICK_DIV constant, shared with the stopwatch prescaler.
- One sub-module, bcd_down_digit:
  - 4-bit register with synchronous load (saturating), decrement-enable input and borrow-out. Borrow-out is high when enabled and the value is 0.
  - Instantiated four times and chained by borrow.
- The top level holds the FSM, the prescaler and the zero detect.

Test Plan (bench uses TICK_DIV=4):
1. Reset and idle: hold rst=0 for 2 cycles, then release → digits=16'h0000, running=0, expired=0. Pulse start → still IDLE, no done_pulse.
2. Full countdown: load 16'h0012, then start → running=1 the next cycle. digits step 0012→0011→…→0000 every 4 cycles. done_pulse fires exactly once, 48 cycles after RUN entry. expired stays 1 until the next load.
3. Borrow ripple: load 16'h1000, start → after the first tick digits=16'h0999. After the next tick digits=16'h0998.
4. Pause/resume:
  - Load 16'h0005, start, pause at prescaler=2 → digits and prescaler hold for 20 cycles.
  - Start → the next tick arrives 2 cycles after resume.
  - Simultaneous start+pause in RUN → PAUSED.
5. Load rules:
  - load 16'h0300 during RUN → ignored, countdown continues.
  - load 16'hABCD in PAUSED → IDLE, digits=16'h9999.
  - load+start on the same cycle in IDLE → IDLE with the new value.
6. Reset mid-run: load 16'h0050, start, drive rst=0 for one cycle after 10 cycles → next cycle IDLE, digits=0000, done_pulse never asserted.
